reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, width of the shared register and of each requester's data.
REQ-002 Parameter: HOLD, 4, maximum consecutive write cycles one requester may own the register (HOLD >= 1).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 Port: wdata  input  4*WIDTH  packed write data; requester i at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-007 Port: grant  output  4  registered one-hot grant; all-zero when idle.
REQ-008 Port: q  output  WIDTH  registered content of the shared register (bank of D flip-flops).
REQ-009 Port: wr  output  1  registered; 1 for exactly the cycle after an edge at which q was written.
REQ-010 Port: busy  output  1  1 while in state GRANT, else 0.

Function
REQ-011 FSM SHALL have two states: IDLE (grant=0) and GRANT (grant one-hot = owner o).
REQ-012 IDLE: at an edge with req!=0 the block SHALL select the new owner by round-robin search starting at ptr, wrapping modulo 4, and enter GRANT with grant set at that edge (grant visible one cycle after req first sampled).
REQ-013 IDLE: q SHALL hold; wr SHALL be 0.
REQ-014 GRANT, edge with req[o]=1: q SHALL load wdata slice o, wr SHALL be 1 the next cycle, hold counter cnt SHALL increment.
REQ-015 GRANT, edge with req[o]=0: no write (q holds, wr=0); owner SHALL be released at this edge.
REQ-016 GRANT, edge with req[o]=1 and cnt==HOLD-1: the write SHALL occur and owner SHALL be released at the same edge.
REQ-017 On release ptr SHALL become (o+1) mod 4; search for the next owner SHALL start at (o+1), wrap, and check o last, using req sampled at the releasing edge.
REQ-018 On release with any qualifying req bit set, the new grant SHALL be active at the releasing edge (no idle bubble) and cnt SHALL clear to 0.
REQ-019 On release with req=0 the FSM SHALL enter IDLE with grant=0 and cnt=0.
REQ-020 Requests from non-owners SHALL never write q; only slice o SHALL be written.
REQ-021 grant SHALL never have more than one bit set; wdata changes on non-owner slices SHALL have no effect.
REQ-022 cnt SHALL be wide enough to count to HOLD-1 and SHALL never exceed it.
REQ-023 HOLD=1: every owner SHALL receive exactly one write per grant, then rotate.

Reset
REQ-024 reset=1 at an edge SHALL force q=0, grant=0, wr=0, busy=0, cnt=0, ptr=0 (requester 0 first priority), state IDLE, overriding any request or ongoing grant.
REQ-025 Reset asserted mid-grant SHALL abort the grant with no write at that edge; the first edge after reset deasserts SHALL behave as IDLE.

Verification
REQ-026 Reset, then req=0001, wdata slice0=8'hA5 -> grant=0001 one cycle later; next edge q=8'hA5, wr=1; continues writing until 4 writes then re-granted to 0 (only requester).
REQ-027 req=1111 held, slices 8'h10/8'h21/8'h32/8'h43 -> grant 0001 for 4 writes, then 0010, 0100, 1000, 0001, no cycle with grant=0 between owners; q sequence matches.
REQ-028 req=0001 dropped after 2 writes (q=8'hA5) -> grant=0 and busy=0 next cycle, q stays 8'hA5, wr=0.
REQ-029 Owner 2 releases by HOLD while req=0101 -> next grant=0001 (search 3,0), ptr=3 after release.
REQ-030 reset pulsed while grant=0100 and req=1111 -> next cycle q=0, grant=0, busy=0; after release, grant=0001 first.
REQ-031 HOLD=1 build, req=0011 held -> grant alternates 0001, 0010 every cycle; wr=1 continuously after first write.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting four requesters write ownership of one shared register,
// with a bounded hold time per owner and back-to-back handover between owners.
module reg_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         grant,
    output logic [WIDTH-1:0]   q,
    output logic               wr,
    output logic               busy
);
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       owner_r, owner_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       grant_r, grant_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic             wr_r, wr_s;
    logic             busy_r, busy_s;
    logic             release_s;
    logic [1:0]       search_start_s;
    logic [2:0]       pick_s;
    logic             pick_ok_s;
    logic [1:0]       pick_idx_s;

    // First requesting index at or after start, wrapping modulo 4; msb flags a hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req_v[idx]) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // A releasing owner searches from its successor, so it is naturally checked last.
    always_comb begin
        search_start_s = (state_r == GRANT) ? (owner_r + 2'd1) : ptr_r;
        pick_s         = rr_pick(req, search_start_s);
        pick_ok_s      = pick_s[2];
        pick_idx_s     = pick_s[1:0];
    end

    // Next-state, ownership, hold counter and register write decisions.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        grant_s   = grant_r;
        q_s       = q_r;
        wr_s      = 1'b0;
        busy_s    = busy_r;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (pick_ok_s) begin
                    state_s = GRANT;
                    owner_s = pick_idx_s;
                    grant_s = 4'b0001 << pick_idx_s;
                    busy_s  = 1'b1;
                end else begin
                    grant_s = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            GRANT: begin
                if (req[owner_r]) begin
                    q_s  = wdata[WIDTH*int'(owner_r) +: WIDTH];
                    wr_s = 1'b1;
                    if (cnt_r == CNT_MAX) begin
                        release_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    release_s = 1'b1;
                end
                // Handover happens at the releasing edge so there is no idle bubble.
                if (release_s) begin
                    ptr_s = owner_r + 2'd1;
                    cnt_s = {CNT_W{1'b0}};
                    if (pick_ok_s) begin
                        state_s = GRANT;
                        owner_s = pick_idx_s;
                        grant_s = 4'b0001 << pick_idx_s;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                        grant_s = 4'b0000;
                        busy_s  = 1'b0;
                    end
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = 4'b0000;
                busy_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any grant without writing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 2'd0;
            ptr_r   <= 2'd0;
            cnt_r   <= {CNT_W{1'b0}};
            grant_r <= 4'b0000;
            q_r     <= {WIDTH{1'b0}};
            wr_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            q_r     <= q_s;
            wr_r    <= wr_s;
            busy_r  <= busy_s;
        end
    end

    assign grant = grant_r;
    assign q     = q_r;
    assign wr    = wr_r;
    assign busy  = busy_r;

    reg_write_arbiter_checker #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_checker (
        .clk   (clk),
        .reset (reset),
        .grant (grant_r),
        .busy  (busy_r),
        .cnt   (cnt_r)
    );
endmodule

// Invariants of the arbiter: single owner, busy tracks grant, hold counter bounded.
module reg_write_arbiter_checker #(
    parameter int                CNT_W   = 2,
    parameter logic [CNT_W-1:0]  CNT_MAX = 2'd3
) (
    input logic             clk,
    input logic             reset,
    input logic [3:0]       grant,
    input logic             busy,
    input logic [CNT_W-1:0] cnt
);
    grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    busy_matches:  assert property (@(posedge clk) disable iff (reset) busy == (grant != 4'b0000));
    cnt_bounded:   assert property (@(posedge clk) disable iff (reset) cnt <= CNT_MAX);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, HOLD=1 rotation and random traffic vs a reference model.
module tb_reg_write_arbiter;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         grant_a, grant_b;
    logic [WIDTH-1:0]   q_a, q_b;
    logic               wr_a, wr_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner index (-1 none), writes in current grant, search pointer.
    int         m_owner [2];
    int         m_n     [2];
    int         m_ptr   [2];
    int         m_hold  [2];
    logic [7:0] m_q     [2];
    logic       m_wr    [2];

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  g;
        logic [7:0]  q;
        logic        wr;
        logic        busy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    reg_write_arbiter #(.WIDTH(WIDTH), .HOLD(4)) dut_a (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .grant(grant_a), .q(q_a), .wr(wr_a), .busy(busy_a)
    );

    reg_write_arbiter #(.WIDTH(WIDTH), .HOLD(1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .grant(grant_b), .q(q_b), .wr(wr_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int  o;
        int  c;
        bit  rel;
        if (reset) begin
            m_owner[k] = -1; m_n[k] = 0; m_ptr[k] = 0; m_q[k] = 8'h00; m_wr[k] = 1'b0;
        end else if (m_owner[k] < 0) begin
            m_wr[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                c = (m_ptr[k] + i) % 4;
                if (req[c] && m_owner[k] < 0) begin
                    m_owner[k] = c;
                    m_n[k] = 0;
                end
            end
        end else begin
            o = m_owner[k];
            if (req[o]) begin
                m_q[k]  = wdata[o*8 +: 8];
                m_wr[k] = 1'b1;
                m_n[k]  = m_n[k] + 1;
                rel     = (m_n[k] == m_hold[k]);
            end else begin
                m_wr[k] = 1'b0;
                rel     = 1'b1;
            end
            if (rel) begin
                m_ptr[k]   = (o + 1) % 4;
                m_owner[k] = -1;
                m_n[k]     = 0;
                for (int i = 1; i <= 4; i++) begin
                    c = (o + i) % 4;
                    if (req[c] && m_owner[k] < 0) m_owner[k] = c;
                end
            end
        end
    endtask

    task automatic model_check(input int k, input logic [3:0] g, input logic [7:0] qv,
                               input logic w, input logic b);
        logic [3:0] eg;
        string      p;
        eg = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
        p  = (k == 0) ? "h4" : "h1";
        check({p, "_grant"}, {28'd0, g}, {28'd0, eg});
        check({p, "_q"},     {24'd0, qv}, {24'd0, m_q[k]});
        check({p, "_wr"},    {31'd0, w}, {31'd0, m_wr[k]});
        check({p, "_busy"},  {31'd0, b}, {31'd0, (m_owner[k] >= 0)});
    endtask

    // One clock edge with inputs already applied; compare both instances to the model.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        model_check(0, grant_a, q_a, wr_a, busy_a);
        model_check(1, grant_b, q_b, wr_b, busy_b);
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] rq, input logic [31:0] wd,
                           input logic [3:0] g, input logic [7:0] qv, input logic w,
                           input logic b, input int times);
        vec_t v;
        v.rst = rst; v.req = rq; v.wdata = wd; v.g = g; v.q = qv; v.wr = w; v.busy = b;
        for (int i = 0; i < times; i++) vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] w1;
        logic [31:0] w2;
        w1 = 32'h4332_21A5;
        w2 = 32'h4332_2110;
        m_hold[0] = 4;
        m_hold[1] = 1;
        reset = 1'b1;
        req   = 4'b0000;
        wdata = w1;

        // Single requester: 4 writes, self re-grant, then drop after 2 writes.
        add_vec(1'b1, 4'b0000, w1, 4'b0000, 8'h00, 1'b0, 1'b0, 1);
        add_vec(1'b0, 4'b0001, w1, 4'b0001, 8'h00, 1'b0, 1'b1, 1);
        add_vec(1'b0, 4'b0001, w1, 4'b0001, 8'hA5, 1'b1, 1'b1, 6);
        add_vec(1'b0, 4'b0000, w1, 4'b0000, 8'hA5, 1'b0, 1'b0, 2);
        // All requesting: full rotation with no idle cycle between owners.
        add_vec(1'b1, 4'b1111, w2, 4'b0000, 8'h00, 1'b0, 1'b0, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h00, 1'b0, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h10, 1'b1, 1'b1, 3);
        add_vec(1'b0, 4'b1111, w2, 4'b0010, 8'h10, 1'b1, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0010, 8'h21, 1'b1, 1'b1, 3);
        add_vec(1'b0, 4'b1111, w2, 4'b0100, 8'h21, 1'b1, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0100, 8'h32, 1'b1, 1'b1, 3);
        add_vec(1'b0, 4'b1111, w2, 4'b1000, 8'h32, 1'b1, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b1000, 8'h43, 1'b1, 1'b1, 3);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h43, 1'b1, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h10, 1'b1, 1'b1, 1);
        // Reset mid-grant of owner 2, then restart from requester 0.
        add_vec(1'b0, 4'b0100, w2, 4'b0100, 8'h10, 1'b0, 1'b1, 1);
        add_vec(1'b1, 4'b1111, w2, 4'b0000, 8'h00, 1'b0, 1'b0, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h00, 1'b0, 1'b1, 1);
        add_vec(1'b0, 4'b1111, w2, 4'b0001, 8'h10, 1'b1, 1'b1, 1);
        // Owner 2 expires its hold with req=0101: search 3 then 0.
        add_vec(1'b0, 4'b0100, w2, 4'b0100, 8'h10, 1'b0, 1'b1, 1);
        add_vec(1'b0, 4'b0101, w2, 4'b0100, 8'h32, 1'b1, 1'b1, 3);
        add_vec(1'b0, 4'b0101, w2, 4'b0001, 8'h32, 1'b1, 1'b1, 1);
        add_vec(1'b0, 4'b0101, w2, 4'b0001, 8'h10, 1'b1, 1'b1, 1);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_grant", i), {28'd0, grant_a}, {28'd0, vecs[i].g});
            check($sformatf("vec%0d_q", i),     {24'd0, q_a},     {24'd0, vecs[i].q});
            check($sformatf("vec%0d_wr", i),    {31'd0, wr_a},    {31'd0, vecs[i].wr});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy_a},  {31'd0, vecs[i].busy});
        end

        // HOLD=1 instance alternates owners every cycle with continuous writes.
        reset = 1'b1; req = 4'b0011; wdata = w2;
        step();
        reset = 1'b0;
        step();
        check("h1seq_first_grant", {28'd0, grant_b}, 32'd1);
        check("h1seq_first_wr",    {31'd0, wr_b},    32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("h1seq%0d_grant", k), {28'd0, grant_b}, (k % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("h1seq%0d_q", k),     {24'd0, q_b},     (k % 2 == 0) ? 32'h10 : 32'h21);
            check($sformatf("h1seq%0d_wr", k),    {31'd0, wr_b},    32'd1);
        end

        // Random traffic with occasional resets, checked against the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0) begin
                req = 4'($urandom_range(0, 15));
            end else begin
                req = req;
            end
            wdata = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
